fault_chain_rx: RTL and testbench

Target-side receiver for the fault-injection serial chain. It deserializes the bit stream driven by the controller (serial data, shift enable, transfer enable, chain reset) into a CHAIN_W-bit fault mask plus a 2-bit fault type. On a transfer-enable pulse it applies that fault to a CHAIN_W-bit target bus. It sits between the controller's serial outputs and the logic under fault test.

---
 rtl/fault_chain_rx.sv | 120 ++++++++++++
 tb/tb_fault_chain_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fault_chain_rx.sv
// Fault-injection serial chain receiver: deserializes mask+ctrl frames and applies them to a target bus.
// Optional `FAULT_FLIP_EN builds the bit-flip (XOR) fault path for ctrl 2'b10.
module fault_chain_rx #(
  parameter int CHAIN_W = 64
) (
  input  logic               i_CLK_SYS,
  input  logic               i_RST_SYS,
  input  logic               i_SERIAL_IN,
  input  logic               i_EN_SR,
  input  logic               i_TFEn,
  input  logic               i_RST,
  input  logic [CHAIN_W-1:0] i_TGT,
  output logic [CHAIN_W-1:0] o_TGT,
  output logic               o_ACTIVE,
  output logic [1:0]         o_CTRL,
  output logic [15:0]        o_RX_CNT,
  output logic               o_ERR,
  output logic               o_OVF
);

  typedef enum logic [1:0] {IDLE, SHIFT, ARMED, APPLIED} state_t;

  localparam logic [15:0] OVF_AT = 16'(CHAIN_W + 3);

  state_t               state;
  logic [CHAIN_W+1:0]   sr;
  logic [15:0]          cnt;
  logic [CHAIN_W-1:0]   mask;
  logic [1:0]           ctrl;
  logic                 active, err, ovf;
  logic                 rst;
  logic [15:0]          cnt_inc;
  logic [CHAIN_W+1:0]   sr_shift;
  logic [CHAIN_W+1:0]   sr_first;

  assign rst      = i_RST_SYS | i_RST;
  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign sr_shift = {sr[CHAIN_W:0], i_SERIAL_IN};
  assign sr_first = {{(CHAIN_W+1){1'b0}}, i_SERIAL_IN};

  always_ff @(posedge i_CLK_SYS) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      mask   <= '0;
      ctrl   <= '0;
      active <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      // Shift always beats transfer; the collision itself is an error.
      if (i_EN_SR && i_TFEn) err <= 1'b1;
      case (state)
        IDLE: begin
          if (i_EN_SR) begin
            sr    <= sr_first;
            cnt   <= 16'd1;
            state <= SHIFT;
          end else if (i_TFEn) begin
            err <= 1'b1;
          end
        end
        SHIFT: begin
          if (i_TFEn) err <= 1'b1;
          if (i_EN_SR) begin
            sr  <= sr_shift;
            cnt <= cnt_inc;
            if (cnt_inc >= OVF_AT) ovf <= 1'b1;
          end else begin
            state <= (cnt >= 16'd3) ? ARMED : IDLE;
          end
        end
        ARMED: begin
          // Resume without clearing so the controller can refill its word buffer.
          if (i_EN_SR) begin
            sr    <= sr_shift;
            cnt   <= cnt_inc;
            if (cnt_inc >= OVF_AT) ovf <= 1'b1;
            state <= SHIFT;
          end else if (i_TFEn) begin
            mask   <= sr[CHAIN_W+1:2];
            ctrl   <= sr[1:0];
            active <= 1'b1;
            state  <= APPLIED;
          end
        end
        APPLIED: begin
          if (i_EN_SR) begin
            sr    <= sr_first;
            cnt   <= 16'd1;
            state <= SHIFT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_TGT = i_TGT;
    if (active) begin
      case (ctrl)
        2'b00:   o_TGT = i_TGT & ~mask;
        2'b01:   o_TGT = i_TGT | mask;
`ifdef FAULT_FLIP_EN
        2'b10:   o_TGT = i_TGT ^ mask;
`endif
        default: o_TGT = i_TGT;
      endcase
    end
  end

  assign o_ACTIVE = active;
  assign o_CTRL   = ctrl;
  assign o_RX_CNT = cnt;
  assign o_ERR    = err;
  assign o_OVF    = ovf;

endmodule

// File: tb/tb_fault_chain_rx.sv
// Self-checking bench for fault_chain_rx: directed plan cases plus randomized frames
// checked against a frame-level reference model.
module tb_fault_chain_rx;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_sys, sin, en_sr, tfen, crst;
  logic [W-1:0] tgt, tgt_o;
  logic         active;
  logic [1:0]   ctrl_o;
  logic [15:0]  rx_cnt;
  logic         err, ovf;

  int n_chk = 0;
  int n_pass = 0;

  fault_chain_rx #(.CHAIN_W(W)) dut (
    .i_CLK_SYS(clk), .i_RST_SYS(rst_sys), .i_SERIAL_IN(sin), .i_EN_SR(en_sr),
    .i_TFEn(tfen), .i_RST(crst), .i_TGT(tgt), .o_TGT(tgt_o), .o_ACTIVE(active),
    .o_CTRL(ctrl_o), .o_RX_CNT(rx_cnt), .o_ERR(err), .o_OVF(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference fault behaviour straight from the fault-type table.
  function automatic logic [W-1:0] ref_fault(input logic act, input logic [1:0] c,
                                             input logic [W-1:0] m, input logic [W-1:0] t);
    if (!act) return t;
    case (c)
      2'b00: return t & ~m;
      2'b01: return t | m;
`ifdef FAULT_FLIP_EN
      2'b10: return t ^ m;
`endif
      default: return t;
    endcase
  endfunction

  function automatic logic [W-1:0] low_bits(input logic [W-1:0] d, input int len);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[i] = d[i];
    return r;
  endfunction

  task automatic idle(input int n);
    en_sr = 1'b0; tfen = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    en_sr = 1'b1; sin = b;
    @(negedge clk);
  endtask

  // Data MSB first, optional gap after gap_at data bits, then ctrl[1], ctrl[0], then one idle cycle.
  task automatic send_frame(input logic [W-1:0] d, input int len, input logic [1:0] c,
                            input int gap_at, input int gap_len);
    for (int i = len - 1; i >= 0; i--) begin
      if ((len - 1 - i) == gap_at && gap_len > 0) idle(gap_len);
      shift_bit(d[i]);
    end
    shift_bit(c[1]);
    shift_bit(c[0]);
    idle(1);
  endtask

  task automatic pulse_tfen();
    tfen = 1'b1; en_sr = 1'b0;
    @(negedge clk);
    tfen = 1'b0;
  endtask

  task automatic pulse_crst();
    crst = 1'b1;
    @(negedge clk);
    crst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d, m, t;
    logic [1:0]   c;
    int           len, gap_at, gap_len;

    rst_sys = 1'b1; crst = 1'b0; sin = 1'b0; en_sr = 1'b0; tfen = 1'b0;
    tgt = 64'h0123_4567_89AB_CDEF;
    repeat (2) @(negedge clk);
    rst_sys = 1'b0;
    chk("rst_active", W'(active), '0);
    chk("rst_ctrl",   W'(ctrl_o), '0);
    chk("rst_cnt",    W'(rx_cnt), '0);
    chk("rst_err",    W'(err), '0);
    chk("rst_ovf",    W'(ovf), '0);
    chk("rst_tgt",    tgt_o, tgt);

    // Stuck-at-1
    tgt = '0;
    send_frame(64'd11, 16, 2'b01, -1, 0);
    chk("sa1_cnt", W'(rx_cnt), 64'd18);
    chk("sa1_pre_active", W'(active), '0);
    pulse_tfen();
    chk("sa1_active", W'(active), 64'd1);
    chk("sa1_ctrl", W'(ctrl_o), 64'd1);
    chk("sa1_tgt", tgt_o, 64'h000B);

    // Stuck-at-0
    tgt = '1;
    send_frame(64'd169723, 32, 2'b00, -1, 0);
    chk("sa1_held", tgt_o, '1);
    pulse_tfen();
    chk("sa0_tgt", tgt_o, {32'hFFFF_FFFF, ~32'd169723});
    chk("sa0_ctrl", W'(ctrl_o), 64'd0);

    // Refill gap: 32 bits, 10 idle cycles, 22 bits + ctrl
    d = 64'h002A_5C3D_9E1F_7B66 & ((64'd1 << 54) - 1);
    send_frame(d, 54, 2'b00, 32, 10);
    chk("gap_cnt", W'(rx_cnt), 64'd56);
    pulse_tfen();
    chk("gap_tgt", tgt_o, ~d);
    chk("gap_err", W'(err), '0);

    // Error: transfer after an unusable 2-bit frame
    pulse_crst();
    chk("crst_active", W'(active), '0);
    chk("crst_tgt", tgt_o, tgt);
    shift_bit(1'b1); shift_bit(1'b0); idle(1);
    pulse_tfen();
    chk("err_set", W'(err), 64'd1);
    chk("err_active", W'(active), '0);
    pulse_crst();
    chk("err_clr", W'(err), '0);

    // Overflow then system reset mid-shift
    for (int i = 0; i < W + 5; i++) shift_bit(1'($urandom_range(0, 1)));
    chk("ovf_set", W'(ovf), 64'd1);
    chk("ovf_cnt", W'(rx_cnt), W'(W + 5));
    rst_sys = 1'b1; sin = 1'b1;
    @(negedge clk);
    rst_sys = 1'b0; en_sr = 1'b0;
    chk("mid_rst_ovf", W'(ovf), '0);
    chk("mid_rst_cnt", W'(rx_cnt), '0);
    chk("mid_rst_active", W'(active), '0);
    chk("mid_rst_tgt", tgt_o, tgt);
    idle(1);

    // Bit-flip
    tgt = 64'hFF;
    send_frame(64'hF0, 8, 2'b10, -1, 0);
    pulse_tfen();
    chk("flip_active", W'(active), 64'd1);
`ifdef FAULT_FLIP_EN
    chk("flip_tgt", tgt_o, 64'h0F);
`else
    chk("flip_tgt", tgt_o, 64'hFF);
`endif

    // Randomized frames against the reference model
    for (int it = 0; it < 30; it++) begin
      len = $urandom_range(1, W);
      d   = {$urandom, $urandom};
      m   = low_bits(d, len);
      c   = 2'($urandom_range(0, 3));
      gap_at  = (len > 4 && $urandom_range(0, 1) == 1) ? $urandom_range(3, len - 1) : -1;
      gap_len = $urandom_range(1, 6);
      send_frame(d, len, c, gap_at, gap_len);
      chk("rnd_cnt", W'(rx_cnt), W'(len + 2));
      pulse_tfen();
      chk("rnd_ctrl", W'(ctrl_o), W'(c));
      chk("rnd_active", W'(active), 64'd1);
      for (int k = 0; k < 2; k++) begin
        t = {$urandom, $urandom};
        tgt = t;
        #1;
        chk("rnd_tgt", tgt_o, ref_fault(1'b1, c, m, t));
      end
      chk("rnd_err", W'(err), '0);
      chk("rnd_ovf", W'(ovf), '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
